// File: rtl/mul_div_sequencer.sv
// Sequential 32-bit multiply/divide unit: shift-add multiply, restoring divide, one bit per clock.
// Latency: done pulses 35 cycles after the start edge (3 cycles for divide by zero).
// Backpressure: busy is high while an operation is in flight; start is ignored unless idle.
//
// Ports: clk, rst (sync, active high); start/op/a/b request (op: 00 MULU, 01 MUL, 10 DIVU, 11 DIV);
//        busy, done (1-cycle pulse), hi/lo results (product halves or remainder/quotient), div_by_zero.
module mul_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, PREP, RUN, FINISH} state_t;

    state_t            state, state_nxt;
    logic [1:0]        op_q;
    logic              sa, sb;          // operand signs, only ever set for signed ops
    logic [WIDTH-1:0]  a_q;             // original dividend, returned on divide by zero
    logic [WIDTH-1:0]  ma, mb;          // operand magnitudes
    logic [W2-1:0]     r, r_run;
    logic [CW-1:0]     cnt;

    logic              is_div, is_signed, d_zero;
    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    rem_sh;
    logic [WIDTH-1:0]  diff;
    logic [W2-1:0]     prod;
    logic [WIDTH-1:0]  quo, rem;

    assign is_div    = op_q[1];
    assign is_signed = op_q[0];
    assign d_zero    = (mb == '0);
    assign busy      = (state != IDLE);

    // One iteration of the working register.
    always_comb begin
        r_run  = r;
        sum    = '0;
        rem_sh = '0;
        diff   = '0;
        if (!is_div) begin
            // Add-then-shift; the carry out of the add lands in bit 63.
            sum   = {1'b0, r[W2-1:WIDTH]} + (r[0] ? {1'b0, ma} : '0);
            r_run = {sum, r[WIDTH-1:1]};
        end else begin
            // Upper half after the left shift, keeping the bit shifted out of R[63]
            // so divisors with the top bit set still compare correctly.
            rem_sh = r[W2-1:WIDTH-1];
            diff   = rem_sh[WIDTH-1:0] - mb;
            if (rem_sh >= {1'b0, mb}) begin
                r_run = {diff, r[WIDTH-2:0], 1'b1};
            end else begin
                r_run = {r[W2-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up of the unsigned result.
    always_comb begin
        prod = (is_signed && (sa ^ sb)) ? -r : r;
        quo  = (sa ^ sb) ? -r[WIDTH-1:0] : r[WIDTH-1:0];
        rem  = sa ? -r[W2-1:WIDTH] : r[W2-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PREP;
            PREP:    state_nxt = (is_div && d_zero) ? FINISH : RUN;
            RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            a_q         <= '0;
            ma          <= '0;
            mb          <= '0;
            r           <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q        <= op;
                        a_q         <= a;
                        sa          <= op[0] & a[WIDTH-1];
                        sb          <= op[0] & b[WIDTH-1];
                        ma          <= (op[0] & a[WIDTH-1]) ? -a : a;
                        mb          <= (op[0] & b[WIDTH-1]) ? -b : b;
                        div_by_zero <= 1'b0;
                    end
                end
                PREP: begin
                    r   <= is_div ? {{WIDTH{1'b0}}, ma} : {{WIDTH{1'b0}}, mb};
                    cnt <= '0;
                end
                RUN: begin
                    r   <= r_run;
                    cnt <= cnt + 1'b1;
                end
                FINISH: begin
                    done <= 1'b1;
                    if (!is_div) begin
                        {hi, lo} <= prod;
                    end else if (d_zero) begin
                        lo          <= '1;
                        hi          <= a_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        lo <= quo;
                        hi <= rem;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mul_div_sequencer.md
# mul_div_sequencer

Multi-cycle integer multiply/divide unit for the 32-bit core's execute stage. It sequences one-bit shifts of a 64-bit working register through the existing 64-bit single-step shifters (`sixtyfour_shift_left`, `sixtyfour_shift_right_unsigned`), one iteration per clock. It produces a 64-bit product or a quotient/remainder pair. The ALU issues one operation with a start pulse, stalls on `busy`, and captures results on the one-cycle `done` pulse.

## Interface
- `WIDTH`, default 32: operand width. Fixed at 32; the working register is 2*WIDTH.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request. Sampled only in IDLE.
- `op`  in  2: operation select. 00 = MULU, 01 = MUL (signed), 10 = DIVU, 11 = DIV (signed).
- `a`  in  32: multiplicand or dividend. Sampled with `start`.
- `b`  in  32: multiplier or divisor. Sampled with `start`.
- `busy`  out  1: high whenever state is not IDLE.
- `done`  out  1: one-cycle pulse when `hi`/`lo` are updated.
- `hi`  out  32: product[63:32], or remainder.
- `lo`  out  32: product[31:0], or quotient.
- `div_by_zero`  out  1: set with `done` for a divide with `b`==0. Cleared on the next accepted start.

## Operation
- States: IDLE, PREP, RUN, FINISH.
- **IDLE**
  - On `start`=1: latch `op`, sign flags (`a[31]`, `b[31]`, signed ops only), and the magnitudes |a| and |b|. Go to PREP.
  - Unsigned ops take operands as-is.
- **PREP**
  - Load the 64-bit working register R. Multiply: R={32'b0,|b|}, with M=|a|. Divide: R={32'b0,|a|}, with D=|b|.
  - Clear the 5-bit iteration counter.
  - For a divide with D==0, go straight to FINISH. Otherwise go to RUN.
- **RUN**, one iteration per cycle, 32 iterations, counter 0..31. Go to FINISH after count 31.
  - Multiply: form the 33-bit sum S = R[63:32] + (R[0] ? M : 0). Next R = {S, R[31:1]}, i.e. a 65-bit right shift with the carry entering bit 63. This uses the unsigned right shifter with the carry forced into bit 63.
  - Divide (restoring): T = R shifted left by one (left shifter). If T[63:32] >= D, then next R = {T[63:32]-D, T[31:1], 1'b1}; else next R = T.
- **FINISH**
  - Multiply: {hi,lo} = R. If signed and the sign flags differ, {hi,lo} = two's-complement negation of R.
  - Divide: lo = R[31:0] (quotient), hi = R[63:32] (remainder).
  - Signed divide: negate the quotient if the sign flags differ. The remainder takes the sign of the dividend.
  - Divide by zero: lo=32'hFFFFFFFF, hi=latched `a` (original, unsigned view), `div_by_zero`=1.
  - Assert `done`, return to IDLE.
- Signed overflow (-2^31 / -1) needs no special case: it yields lo=32'h80000000, hi=0.
- MUL of -2^31 × -2^31 yields 64'h4000000000000000.
- `start` while busy is ignored; no queuing.
- `start` in the same cycle `done` is high is accepted, since the state is already IDLE.

## Timing
- **Reset:** state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0, counter=0. Reset mid-operation aborts immediately; no `done` is produced.
- **Normal latency:** `start` sampled at edge E0.
  - PREP follows E0.
  - RUN covers edges E2..E33.
  - FINISH completes at E34.
  - `done`=1 in the cycle after E34, i.e. 35 cycles after the start edge.
- **Divide by zero:** `done` in the cycle after E2, 3 cycles after the start edge.
- **`busy`** is high from the cycle after E0 through the FINISH cycle. It is low in the `done` cycle.
- **Result hold:** `hi`/`lo`/`div_by_zero` hold their values until the next FINISH or reset.
- **`done`** is high for exactly one cycle.

## Test plan
- **MULU:** MULU a=32'hFFFFFFFF, b=32'hFFFFFFFF → after 35 cycles, hi=32'hFFFFFFFE, lo=32'h00000001, one `done` pulse.
- **MUL signed:** MUL a=-7 (32'hFFFFFFF9), b=6 → hi=32'hFFFFFFFF, lo=32'hFFFFFFD6. MUL a=32'h80000000, b=32'h80000000 → hi=32'h40000000, lo=0.
- **DIV signed:**
  - DIV a=-7, b=2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
  - DIVU a=100, b=7 → lo=14, hi=2.
  - DIV a=32'h80000000, b=32'hFFFFFFFF → lo=32'h80000000, hi=0.
- **Divide by zero:** DIVU a=32'h12345678, b=0 → `done` 3 cycles after start, lo=32'hFFFFFFFF, hi=32'h12345678, `div_by_zero`=1. The next MULU clears `div_by_zero`.
- **Start while busy:** pulse `start` with different operands at cycle 10 of a running op → ignored, and the first result is unchanged. Assert `start` during the `done` cycle → accepted, with `busy` high the next cycle.
- **Reset mid-operation:** assert `rst` at RUN iteration 15 → next cycle `busy`=0, `hi`=`lo`=0, and no `done` pulse. A fresh op afterwards completes correctly in 35 cycles.
